// File: rtl/gyruss_lpf_bank_if.sv
// Sample bus for gyruss_lpf_bank: packed per-channel inputs, mode selects,
// filtered outputs and the status strobes.
interface gyruss_lpf_bank_if #(
    parameter int CHANNELS = 3
);
    logic [16*CHANNELS-1:0] in;
    logic [2*CHANNELS-1:0]  sel;
    logic [16*CHANNELS-1:0] out;
    logic                   out_valid;
    logic                   overrun;

    modport master (output in, sel, input out, out_valid, overrun);
    modport slave  (input in, sel, output out, out_valid, overrun);
endinterface

// File: rtl/gyruss_lpf_bank.sv
// Time-multiplexed first-order IIR low-pass bank, one shared MAC stepped per sample tick.
// Optional build macro GYRUSS_LPF_ROUND_EN: round-half-up before the >>>15 instead of floor.
module gyruss_lpf_bank #(
    parameter int CHANNELS     = 3,
    parameter int DIV          = 220,
    parameter int DIVW         = 10,
    parameter int A2_L         = -29128,
    parameter int B_L          = 1820,
    parameter int A2_M         = -31456,
    parameter int B_M          = 656,
    parameter int A2_H         = -32498,
    parameter int B_H          = 135,
    parameter bit DIV_CHECK_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    gyruss_lpf_bank_if.slave   bus
);

    // state | meaning
    // IDLE  | waiting for a sample tick
    // MB1   | acc = B * x
    // MB2   | acc += B * x_prev
    // MA2   | acc -= A2 * y_prev
    // WB    | saturate and write back channel ch
    // DONE  | pulse out_valid
    typedef enum logic [2:0] {S_IDLE, S_MB1, S_MB2, S_MA2, S_WB, S_DONE} state_e;

    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);
    localparam logic [CHW-1:0]  CH_LAST  = CHW'(CHANNELS - 1);

    localparam logic signed [17:0] CB_L  = 18'(B_L);
    localparam logic signed [17:0] CA2_L = 18'(A2_L);
    localparam logic signed [17:0] CB_M  = 18'(B_M);
    localparam logic signed [17:0] CA2_M = 18'(A2_M);
    localparam logic signed [17:0] CB_H  = 18'(B_H);
    localparam logic signed [17:0] CA2_H = 18'(A2_H);

    if (CHANNELS < 1 || CHANNELS > 8) begin : g_ch_err
        $error("gyruss_lpf_bank: CHANNELS must be 1..8");
    end
    if (DIV_CHECK_EN && (DIV < 4*CHANNELS + 2)) begin : g_div_err
        $error("gyruss_lpf_bank: DIV too small for CHANNELS");
    end
    if (DIV > (1 << DIVW)) begin : g_divw_err
        $error("gyruss_lpf_bank: DIVW too narrow for DIV");
    end

    logic [DIVW-1:0]       div_q, div_d;
    state_e                state_q, state_d;
    logic [CHW-1:0]        ch_q, ch_d;
    logic signed [39:0]    acc_q, acc_d;
    logic                  out_valid_q, out_valid_d;
    logic                  overrun_q, overrun_d;
    logic signed [15:0]    x_snap_q [CHANNELS];
    logic signed [15:0]    x_snap_d [CHANNELS];
    logic [1:0]            sel_snap_q [CHANNELS];
    logic [1:0]            sel_snap_d [CHANNELS];
    logic signed [15:0]    x_prev_q [CHANNELS];
    logic signed [15:0]    x_prev_d [CHANNELS];
    logic signed [15:0]    y_prev_q [CHANNELS];
    logic signed [15:0]    y_prev_d [CHANNELS];
    logic signed [15:0]    out_q [CHANNELS];
    logic signed [15:0]    out_d [CHANNELS];

    logic                  tick;
    logic signed [15:0]    x_cur;
    logic [1:0]            mode;
    logic signed [17:0]    coef_b, coef_a2;
    logic signed [15:0]    mul_a;
    logic signed [17:0]    mul_b;
    logic signed [33:0]    mul_a_x, mul_b_x, prod;
    logic signed [39:0]    prod_ext;
    logic signed [39:0]    wb_sum, wb_shift;
    logic signed [15:0]    y_sat, y_wb;

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        div_d = tick ? '0 : div_q + DIVW'(1);
    end

    // Shared datapath: operand muxing driven by the current state and channel.
    always_comb begin
        x_cur = x_snap_q[ch_q];
        mode  = sel_snap_q[ch_q];
        case (mode)
            2'd1:    begin coef_b = CB_L; coef_a2 = CA2_L; end
            2'd2:    begin coef_b = CB_M; coef_a2 = CA2_M; end
            2'd3:    begin coef_b = CB_H; coef_a2 = CA2_H; end
            default: begin coef_b = '0;   coef_a2 = '0;    end
        endcase
        case (state_q)
            S_MB1:   mul_a = x_cur;
            S_MB2:   mul_a = x_prev_q[ch_q];
            default: mul_a = y_prev_q[ch_q];
        endcase
        mul_b    = (state_q == S_MA2) ? coef_a2 : coef_b;
        mul_a_x  = {{18{mul_a[15]}}, mul_a};
        mul_b_x  = {{16{mul_b[17]}}, mul_b};
        prod     = mul_a_x * mul_b_x;
        prod_ext = {{6{prod[33]}}, prod};
`ifdef GYRUSS_LPF_ROUND_EN
        wb_sum   = acc_q + 40'sd16384;
`else
        wb_sum   = acc_q;
`endif
        wb_shift = wb_sum >>> 15;
        if (wb_shift > 40'sd32767) begin
            y_sat = 16'sh7fff;
        end else if (wb_shift < -40'sd32768) begin
            y_sat = 16'sh8000;
        end else begin
            y_sat = wb_shift[15:0];
        end
        y_wb = (mode == 2'd0) ? x_cur : y_sat;
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q | (tick && (state_q != S_IDLE));
        x_snap_d    = x_snap_q;
        sel_snap_d  = sel_snap_q;
        x_prev_d    = x_prev_q;
        y_prev_d    = y_prev_q;
        out_d       = out_q;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    for (int k = 0; k < CHANNELS; k++) begin
                        x_snap_d[k]   = bus.in[16*k +: 16];
                        sel_snap_d[k] = bus.sel[2*k +: 2];
                    end
                    ch_d    = '0;
                    state_d = S_MB1;
                end
            end
            S_MB1: begin
                acc_d   = prod_ext;
                state_d = S_MB2;
            end
            S_MB2: begin
                acc_d   = acc_q + prod_ext;
                state_d = S_MA2;
            end
            S_MA2: begin
                acc_d   = acc_q - prod_ext;
                state_d = S_WB;
            end
            S_WB: begin
                out_d[ch_q]    = y_wb;
                y_prev_d[ch_q] = y_wb;
                x_prev_d[ch_q] = x_cur;
                if (ch_q == CH_LAST) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + CHW'(1);
                    state_d = S_MB1;
                end
            end
            S_DONE: begin
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q       <= '0;
            state_q     <= S_IDLE;
            ch_q        <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                x_snap_q[k]   <= '0;
                sel_snap_q[k] <= '0;
                x_prev_q[k]   <= '0;
                y_prev_q[k]   <= '0;
                out_q[k]      <= '0;
            end
        end else begin
            div_q       <= div_d;
            state_q     <= state_d;
            ch_q        <= ch_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            x_snap_q    <= x_snap_d;
            sel_snap_q  <= sel_snap_d;
            x_prev_q    <= x_prev_d;
            y_prev_q    <= y_prev_d;
            out_q       <= out_d;
        end
    end

    always_comb begin
        bus.out = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            bus.out[16*k +: 16] = out_q[k];
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_gyruss_lpf_bank.sv
// Scoreboard bench for gyruss_lpf_bank: a reference filter model queues the expected
// outputs per tick, popped at out_valid; a side monitor checks update timing.
module tb_gyruss_lpf_bank;

    localparam int CH  = 3;
    localparam int DIV = 220;
    localparam int A2_L = -29128, B_L = 1820;
    localparam int A2_M = -31456, B_M = 656;
    localparam int A2_H = -32498, B_H = 135;
`ifdef GYRUSS_LPF_ROUND_EN
    localparam longint RND = 16384;
`else
    localparam longint RND = 0;
`endif

    typedef struct { longint v [CH]; } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sb_q [$];
    longint xp [CH];
    longint yp [CH];
    longint prev [CH];

    gyruss_lpf_bank_if #(.CHANNELS(CH)) bus_m ();
    gyruss_lpf_bank_if #(.CHANNELS(CH)) bus_o ();

    gyruss_lpf_bank #(.CHANNELS(CH), .DIV(DIV)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_m)
    );

    gyruss_lpf_bank #(.CHANNELS(CH), .DIV(10), .DIV_CHECK_EN(1'b0)) u_ovr (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic longint ch_out(input logic [16*CH-1:0] v, input int c);
        logic signed [15:0] s;
        s = v[16*c +: 16];
        return longint'(s);
    endfunction

    function automatic longint lpf_calc(input longint b, input longint a2, input longint x,
                                        input longint xq, input longint yq);
        longint acc;
        acc = b*x + b*xq - a2*yq + RND;
        acc = acc >>> 15;
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    task automatic model_step(input int c, input longint x, input int s, output longint y);
        case (s)
            1:       y = lpf_calc(B_L, A2_L, x, xp[c], yp[c]);
            2:       y = lpf_calc(B_M, A2_M, x, xp[c], yp[c]);
            3:       y = lpf_calc(B_H, A2_H, x, xp[c], yp[c]);
            default: y = x;
        endcase
        xp[c] = x;
        yp[c] = y;
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            xp[c] = 0;
            yp[c] = 0;
        end
    endtask

    // ch0 heavy step, ch1 bypass then light, ch2 light with full-scale alternation
    task automatic drive_sample(input int n);
        longint xs [CH];
        int     ss [CH];
        exp_t   e;
        xs[0] = 10000;  ss[0] = 3;
        xs[1] = -5000;  ss[1] = (n <= 3) ? 0 : 1;
        xs[2] = (n % 2 == 1) ? 32767 : -32768;  ss[2] = 1;
        for (int c = 0; c < CH; c++) begin
            bus_m.in[16*c +: 16] = 16'(xs[c]);
            bus_m.sel[2*c +: 2]  = 2'(ss[c]);
            model_step(c, xs[c], ss[c], e.v[c]);
        end
        sb_q.push_back(e);
    endtask

    task automatic compare_sample(input int s);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            for (int c = 0; c < CH; c++)
                chk($sformatf("s%0d_ch%0d", s, c), ch_out(bus_m.out, c), e.v[c]);
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2*DIV; i++) begin
            @(posedge clk); #1;
            if (bus_m.out_valid) begin
                ok = 1'b1;
                return;
            end
        end
        chk("valid_timeout", 0, 1);
    endtask

    task automatic wait_phase(input int ph, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < DIV + 5; i++) begin
            @(posedge clk); #1;
            if (cyc >= DIV && (cyc % DIV) == ph) begin
                ok = 1'b1;
                return;
            end
        end
        chk("phase_timeout", 0, 1);
    endtask

    // Each out channel may only change at tick+4*ch+4; out_valid only at tick+4*CH+1.
    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            for (int c = 0; c < CH; c++) prev[c] = 0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (ch_out(bus_m.out, c) != prev[c])
                    chk($sformatf("upd_t_ch%0d", c), cyc % DIV, 4*c + 4);
                prev[c] = ch_out(bus_m.out, c);
            end
            if (bus_m.out_valid) chk("valid_t", cyc % DIV, 4*CH + 1);
        end
    end

    initial begin
        bit     ok;
        bit     ovr_set;
        int     pulses;
        longint yo, xo, yn;

        reset_n   = 1'b0;
        bus_m.in  = {CH{16'sd1234}};
        bus_m.sel = '0;
        bus_o.in  = {CH{16'sd1234}};
        bus_o.sel = '0;
        model_reset();
        repeat (5) @(posedge clk);
        #1;
        chk("rst_out", longint'(bus_m.out), 0);
        chk("rst_valid", longint'(bus_m.out_valid), 0);
        chk("rst_overrun", longint'(bus_m.overrun), 0);
        chk("rst_ovr_overrun", longint'(bus_o.overrun), 0);

        @(negedge clk);
        drive_sample(1);
        bus_o.in  = '0;
        bus_o.sel = '0;
        bus_o.in[15:0] = 16'sd1000;
        bus_o.sel[1:0] = 2'd1;
        reset_n = 1'b1;

        // DIV=10 instance: every second tick lands while busy
        ovr_set = 1'b0;
        pulses  = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (bus_o.out_valid) pulses++;
            if (ovr_set) chk("ovr_sticky", longint'(bus_o.overrun), 1);
            else if (bus_o.overrun) ovr_set = 1'b1;
        end
        chk("ovr_set", longint'(ovr_set), 1);
        chk("ovr_pulses", pulses, 2);
        xo = 0;
        yo = 0;
        for (int k = 0; k < 3; k++) begin
            yn = lpf_calc(B_L, A2_L, 1000, xo, yo);
            xo = 1000;
            yo = yn;
        end
        chk("ovr_out0", ch_out(bus_o.out, 0), yo);

        wait_valid(ok);
        chk("first_valid_t", cyc, DIV + 4*CH + 1);
        for (int s = 1; s <= 8; s++) begin
            if (s > 1) wait_valid(ok);
            compare_sample(s);
            if (s == 1) chk("heavy_first", ch_out(bus_m.out, 0), 41);
            if (s == 2) chk("heavy_second", ch_out(bus_m.out, 0), 123);
            if (s <= 3) chk("bypass_ch1", ch_out(bus_m.out, 1), -5000);
            if (s == 4) chk("switch_in_ch1", ch_out(bus_m.out, 1), -5000);
            drive_sample(s + 1);
            if (s == 5) begin
                wait_phase(2, ok);
                bus_m.in  = 48'({$urandom(), $urandom()});
                bus_m.sel = 6'($urandom());
            end
        end

        // Reset during the sequence of sample 9
        wait_phase(6, ok);
        reset_n = 1'b0;
        #1;
        chk("midrst_out", longint'(bus_m.out), 0);
        chk("midrst_valid", longint'(bus_m.out_valid), 0);
        sb_q.delete();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        drive_sample(1);
        reset_n = 1'b1;
        wait_valid(ok);
        chk("restart_valid_t", cyc, DIV + 4*CH + 1);
        compare_sample(100);
        chk("restart_heavy", ch_out(bus_m.out, 0), 41);
        chk("no_overrun", longint'(bus_m.overrun), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gyruss_lpf_bank.md
Name: gyruss_lpf_bank

Overview:
- Multi-channel, time-multiplexed first-order IIR low-pass bank for the Gyruss sound mix.
- One filter per sound channel; each channel picks bypass, light, medium or heavy at run time.
- Coefficients are parameters. All channels share one multiplier/accumulator, stepped by an FSM once per sample tick.
- Sits between the per-channel sound sources and the final mixer, clocked from the 49.152 MHz audio clock.

Parameters:
- CHANNELS, 3, number of filtered channels (1..8).
- DIV, 220, clocks per sample tick (49.152 MHz / 220 = 223418 Hz); must be >= 4*CHANNELS+2, else elaboration error.
- DIVW, 10, width of the sample divider counter.
- A2_L / B_L, -29128 / 1820, light coefficients: feedback / feedforward (B1=B2=B).
- A2_M / B_M, -31456 / 656, medium coefficients.
- A2_H / B_H, -32498 / 135, heavy coefficients.

Ports:
- clk, in, 1: audio clock.
- reset_n, in, 1: asynchronous, active-low reset.
- in, in, 16*CHANNELS: signed samples; channel k occupies bits [16k+15:16k].
- sel, in, 2*CHANNELS: per-channel mode, 0=bypass, 1=light, 2=medium, 3=heavy.
- out, out, 16*CHANNELS: signed filtered samples, same packing as in.
- out_valid, out, 1: one-cycle pulse when all channels of out have been updated.
- overrun, out, 1: sticky flag, set when a tick arrives while the FSM is busy.

Behaviour:
- Reset (reset_n low, asynchronous):
  - div counter = 0; FSM = IDLE.
  - All out, x_prev, y_prev, accumulator = 0.
  - out_valid = 0; overrun = 0.
- Divider:
  - Counts 0..DIV-1, then wraps to 0.
  - tick is asserted on the cycle the count equals DIV-1.
  - First tick comes DIV cycles after reset release.
- On tick in IDLE:
  - Snapshot all in and sel into internal registers.
  - Set ch = 0 and go to MB1.
- On tick when not IDLE:
  - The tick is dropped and overrun is set.
  - overrun is cleared only by reset.
- FSM, per channel ch, one cycle per state:
  - MB1: acc = B*x.
  - MB2: acc += B*x_prev.
  - MA2: acc -= A2*y_prev.
  - WB: y = sat16(acc >>> 15). Write out[ch] = y; y_prev[ch] = y; x_prev[ch] = x.
  - After WB: if ch < CHANNELS-1, then ch++ and go to MB1; else go to DONE.
  - DONE: pulse out_valid for one cycle, then return to IDLE.
- Latency:
  - out[ch] updates 4*ch+4 cycles after tick.
  - out_valid is asserted 4*CHANNELS+1 cycles after tick.
  - out holds its value between updates.
- Arithmetic:
  - Products are 16x18 signed, 34 bits; accumulator is 40-bit signed.
  - The shift is arithmetic (floor).
  - sat16 clamps to the range -32768..32767.
  - Each coefficient set has unity DC gain: 2B - A2 = 32768.
- Bypass (sel=0):
  - The channel still takes its 4-cycle slot, but WB writes out[ch] = x with no arithmetic.
  - x_prev = x and y_prev = x, so switching into a filter mode later is glitch-free.
- Mode change between samples:
  - Filter state is kept; new coefficients apply from the next tick.
  - A sel change mid-sequence has no effect, because sel is snapshotted at tick.
- Reset mid-sequence:
  - Abandons the sequence immediately; all state returns to reset values.
  - out_valid is not pulsed.
- in changes between ticks are ignored; only the snapshot is used.

Optional Feature:
- Macro: GYRUSS_LPF_ROUND_EN.
- Defined: WB adds 2^14 to acc before the >>>15, giving round-half-up.
- Undefined: plain floor shift.
- Cycle timing is identical in both builds.

Test Plan:
- Reset behaviour:
  - Stimulus: hold reset_n low for 5 cycles, with in held at 1234 on all channels.
  - Response: out = 0, out_valid = 0, overrun = 0. First out_valid pulse occurs exactly DIV + 4*CHANNELS + 1 cycles after release.
- Heavy step, floor build:
  - Stimulus: ch0 sel=3, in=10000 constant.
  - Response: first out = 41; second out = 123. Converges to 10000 ±1 within 4000 samples.
- Bypass and switch-in:
  - Stimulus: ch1 sel=0 with in = -5000 for 3 samples, then sel=1.
  - Response: bypass out = -5000 each sample; first filtered sample is also -5000, with no step.
- Saturation and ordering:
  - Stimulus: ch2 sel=1; in alternating +32767 / -32768 each sample.
  - Response: out stays within -32768..32767 with no wrap. out[0], out[1] and out[2] update at tick+4, +8 and +12 cycles; out_valid at tick+13.
- Overrun, with DIV overridden to 20 and CHANNELS=8:
  - Response: elaboration error.
  - With the divider check forced via a bench hook and an extra tick injected while busy: overrun goes to 1 and stays 1; the in-flight sequence still completes.
- Reset mid-sequence:
  - Stimulus: assert reset_n low at tick+6.
  - Response: all out = 0 immediately; no out_valid pulse; the next sequence restarts from zero state.
